// File: rtl/tile_feat_frame_buf_if.sv
// Feature-stream and read-port bundle for tile_feat_frame_buf.
// master: feature producer / reader; slave: the frame buffer.
interface tile_feat_frame_buf_if #(
  parameter int TILE_ID_W = 3,
  parameter int FEAT_W    = 16,
  parameter int FEAT_DIM  = 4
);
  logic                       feat_valid;
  logic                       feat_ready;
  logic [15:0]                tile_i;
  logic [15:0]                tile_j;
  logic [TILE_ID_W-1:0]       tile_id;
  logic [FEAT_DIM*FEAT_W-1:0] feat_vec;
  logic                       rd_en;
  logic [TILE_ID_W-1:0]       rd_addr;
  logic                       rd_valid;
  logic [FEAT_DIM*FEAT_W-1:0] rd_data;

  modport master (
    output feat_valid, tile_i, tile_j, tile_id, feat_vec, rd_en, rd_addr,
    input  feat_ready, rd_valid, rd_data
  );

  modport slave (
    input  feat_valid, tile_i, tile_j, tile_id, feat_vec, rd_en, rd_addr,
    output feat_ready, rd_valid, rd_data
  );
endinterface

// File: rtl/tile_feat_frame_buf.sv
// Ping-pong tile feature memory. Collects one frame of per-tile features,
// checks tile indexing and coverage, and publishes a bank atomically once
// every tile has been written. Optional macro TILE_FEAT_EMA_EN smooths each
// written feature against the currently published frame.
//
// state   | meaning
// FILL    | accepting beats into the fill bank (~bank_sel)
// PUBLISH | one bubble cycle: swap banks, pulse frame_done, clear coverage
module tile_feat_frame_buf #(
  parameter int TILES_X   = 4,
  parameter int TILES_Y   = 2,
  parameter int FEAT_W    = 16,
  parameter int FEAT_DIM  = 4,
  parameter int EMA_SHIFT = 2,
  localparam int N_TILES   = TILES_X * TILES_Y,
  localparam int TILE_ID_W = ($clog2(N_TILES) > 1) ? $clog2(N_TILES) : 1,
  localparam int DW        = FEAT_DIM * FEAT_W,
  localparam int CNT_W     = TILE_ID_W + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en_i,
  input  logic                 frame_start_i,
  tile_feat_frame_buf_if.slave bus,
  output logic                 bank_sel_o,
  output logic                 frame_done_o,
  output logic [15:0]          frame_cnt_o,
  output logic                 err_id_o,
  output logic                 err_dup_o,
  output logic                 err_incomplete_o,
  output logic [CNT_W-1:0]     cov_cnt_o
);

  localparam logic [0:0] ST_FILL    = 1'b0;
  localparam logic [0:0] ST_PUBLISH = 1'b1;

  logic [0:0]         state_q;
  logic               bank_sel_q;
  logic [15:0]        frame_cnt_q;
  logic [N_TILES-1:0] cov_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               err_id_q, err_dup_q, err_inc_q;
  logic               rd_valid_q;
  logic [DW-1:0]      rd_data_q;
  logic [DW-1:0]      mem_q [2][N_TILES];

  logic               accept, sof_clr, id_ok, is_dup, do_write, last_write;
  logic [33:0]        exp_id;
  logic [N_TILES-1:0] cov_base;
  logic [CNT_W-1:0]   cnt_base;
  logic [DW-1:0]      wr_data;

  assign bus.feat_ready = en_i && (state_q == ST_FILL);
  assign accept         = bus.feat_valid && bus.feat_ready;

  // A new frame with partial coverage abandons the old one before this cycle's beat is counted.
  assign sof_clr  = frame_start_i && (state_q == ST_FILL) && (cnt_q != '0);
  assign cov_base = sof_clr ? '0 : cov_q;
  assign cnt_base = sof_clr ? '0 : cnt_q;

  assign exp_id     = 34'(bus.tile_i) * 34'(TILES_X) + 34'(bus.tile_j);
  assign id_ok      = (34'(bus.tile_id) < 34'(N_TILES)) && (34'(bus.tile_id) == exp_id);
  assign is_dup     = id_ok && cov_base[bus.tile_id];
  assign do_write   = accept && id_ok && !is_dup;
  assign last_write = do_write && (cnt_base == CNT_W'(N_TILES - 1));

`ifdef TILE_FEAT_EMA_EN
  logic                     pub_seen_q;
  logic [FEAT_W-1:0]        old_f, new_f;
  logic signed [FEAT_W:0]   diff_f, step_f;

  // Blend the incoming features toward the published frame once one exists.
  always_comb begin
    wr_data = bus.feat_vec;
    old_f   = '0;
    new_f   = '0;
    diff_f  = '0;
    step_f  = '0;
    if (pub_seen_q) begin
      for (int k = 0; k < FEAT_DIM; k++) begin
        old_f  = mem_q[bank_sel_q][bus.tile_id][k*FEAT_W +: FEAT_W];
        new_f  = bus.feat_vec[k*FEAT_W +: FEAT_W];
        diff_f = $signed({1'b0, new_f}) - $signed({1'b0, old_f});
        step_f = diff_f >>> EMA_SHIFT;
        wr_data[k*FEAT_W +: FEAT_W] = old_f + step_f[FEAT_W-1:0];
      end
    end
  end

  // Remembers whether any frame has been published since reset.
  always_ff @(posedge clk) begin
    if (rst) pub_seen_q <= 1'b0;
    else if (state_q == ST_PUBLISH) pub_seen_q <= 1'b1;
  end
`else
  logic [31:0] unused_ema_shift;
  assign unused_ema_shift = 32'(EMA_SHIFT);
  assign wr_data = bus.feat_vec;
`endif

  // Sequencing, coverage tracking, bank swap and error pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_FILL;
      bank_sel_q  <= 1'b0;
      frame_cnt_q <= '0;
      cov_q       <= '0;
      cnt_q       <= '0;
      err_id_q    <= 1'b0;
      err_dup_q   <= 1'b0;
      err_inc_q   <= 1'b0;
    end else begin
      err_id_q  <= accept && !id_ok;
      err_dup_q <= accept && is_dup;
      err_inc_q <= sof_clr;
      if (state_q == ST_PUBLISH) begin
        state_q     <= ST_FILL;
        bank_sel_q  <= ~bank_sel_q;
        frame_cnt_q <= frame_cnt_q + 16'd1;
        cov_q       <= '0;
        cnt_q       <= '0;
      end else begin
        cov_q <= do_write ? (cov_base | (N_TILES'(1) << bus.tile_id)) : cov_base;
        cnt_q <= cnt_base + CNT_W'(do_write);
        if (last_write) state_q <= ST_PUBLISH;
      end
    end
  end

  // Tile feature storage; writes always land in the bank not being read.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < 2; b++)
        for (int t = 0; t < N_TILES; t++)
          mem_q[b][t] <= '0;
    end else if (do_write) begin
      mem_q[~bank_sel_q][bus.tile_id] <= wr_data;
    end
  end

  // Registered read of the published bank; out-of-range addresses read as zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= bus.rd_en;
      if (bus.rd_en)
        rd_data_q <= (32'(bus.rd_addr) < N_TILES) ? mem_q[bank_sel_q][bus.rd_addr] : '0;
    end
  end

  assign bus.rd_valid     = rd_valid_q;
  assign bus.rd_data      = rd_data_q;
  assign bank_sel_o       = bank_sel_q;
  assign frame_done_o     = (state_q == ST_PUBLISH);
  assign frame_cnt_o      = frame_cnt_q;
  assign err_id_o         = err_id_q;
  assign err_dup_o        = err_dup_q;
  assign err_incomplete_o = err_inc_q;
  assign cov_cnt_o        = cnt_q;

endmodule

// File: doc/tile_feat_frame_buf.md
# tile_feat_frame_buf

Downstream consumer of the pixel-to-tile feature extractor: accepts the per-tile feature stream (valid/ready, tile_i/tile_j/tile_id, packed feature vector), checks tile indexing and per-frame coverage, and stores the features into a ping-pong tile feature memory. When every tile of a frame has been written, it publishes that bank atomically, so the compensation logic reads a complete, stable frame of tile features through a 1-cycle-latency read port.

## Interface
- TILES_X, 4, tiles per row
- TILES_Y, 2, tile rows
- N_TILES, TILES_X*TILES_Y, tiles per frame
- TILE_ID_W, max(1,$clog2(N_TILES)), tile id / read address width
- FEAT_W, 16, bits per feature
- FEAT_DIM, 4, features per tile
- EMA_SHIFT, 2, smoothing shift (used only with TILE_FEAT_EMA_EN)

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- en  in  1  global enable; 0 holds feat_ready low
- frame_start  in  1  pulse on accepted SOF pixel upstream
- feat_valid  in  1  feature beat valid
- feat_ready  out  1  feature beat accepted when valid&ready
- tile_i  in  16  tile row
- tile_j  in  16  tile column
- tile_id  in  TILE_ID_W  linear tile id
- feat_vec  in  FEAT_DIM*FEAT_W  features, feature k at [k*FEAT_W +: FEAT_W]
- rd_en  in  1  read request
- rd_addr  in  TILE_ID_W  tile id to read
- rd_valid  out  1  rd_data valid (1 cycle after rd_en)
- rd_data  out  FEAT_DIM*FEAT_W  features from published bank
- bank_sel  out  1  published bank index
- frame_done  out  1  1-cycle pulse on publish
- frame_cnt  out  16  published frames, wraps
- err_id  out  1  pulse: id out of range or id != tile_i*TILES_X+tile_j
- err_dup  out  1  pulse: tile already written this frame
- err_incomplete  out  1  pulse: frame_start with partial coverage
- cov_cnt  out  TILE_ID_W+1  tiles written in current frame

## Operation
- Storage: bank[2][N_TILES] of FEAT_DIM*FEAT_W bits; coverage bitmap cov[N_TILES]; fill bank = ~bank_sel.
- FSM FILL: feat_ready = en. On accept:
  - id >= N_TILES or id != tile_i*TILES_X+tile_j → err_id, beat discarded.
  - else cov[id]=1 → err_dup, beat discarded, stored value kept.
  - else write fill bank[id], set cov[id], cov_cnt++.
  - If this write makes cov_cnt == N_TILES → PUBLISH.
- FSM PUBLISH (exactly 1 cycle): feat_ready=0; bank_sel toggles, frame_done=1, frame_cnt++, cov and cov_cnt cleared; → FILL.
- frame_start in FILL with 0 < cov_cnt < N_TILES: err_incomplete, cov/cov_cnt cleared, no publish; fill bank contents stale but never published unless rewritten.
- frame_start with cov_cnt==0, or in PUBLISH: no effect, no error.
- frame_start and accept same cycle: clear applied first; accepted tile counts in new frame.
- Errors are independent pulses; at most one of err_id/err_dup per beat.
- Read: rd_data registered from bank[bank_sel][rd_addr] using bank_sel before the edge; rd_addr >= N_TILES returns 0 with rd_valid=1.

## Timing
- Reset: feat_ready=0, rd_valid=0, rd_data=0, bank_sel=0, frame_done=0, frame_cnt=0, all err pulses 0, cov_cnt=0, state FILL, bank contents 0.
- feat_ready is combinational from state and en only (no dependence on feat_valid).
- Write visible in fill bank at the accepting edge; frame_done asserts the cycle after the final accepting edge; feat_ready low that cycle.
- Read latency 1; read issued in PUBLISH cycle returns old bank, next cycle returns new bank.
- Reset mid-frame discards coverage and returns to FILL immediately.
- Throughput: N_TILES beats + 1 bubble per frame.

## Configuration
- TILE_FEAT_EMA_EN defined: written value per feature = old + (diff >>> EMA_SHIFT), old = published bank[id] feature, diff = {1'b0,new} - {1'b0,old} signed FEAT_W+1 bits; result fits FEAT_W. Before first publish after reset, raw value stored.
- Undefined: raw feature written; no read of published bank on write path.

## Test plan
- Tiles id 0..7 in order, feat0=id*10, ready path free → frame_done 1 cycle after 8th accept, bank_sel 0→1, frame_cnt=1; rd_addr=3 → rd_data feat0=30 one cycle later.
- id 2 sent twice (second feat0=99) → err_dup once, cov_cnt stays, stored feat0=20, frame_done after 8 unique ids.
- tile_i=1, tile_j=0, tile_id=0 → err_id, cov_cnt unchanged, no write.
- 5 tiles then frame_start → err_incomplete, cov_cnt=0, no frame_done, bank_sel unchanged; following full frame publishes normally.
- en=0 for 10 cycles mid-frame with feat_valid=1 → feat_ready=0, no accepts; resume completes frame; rst mid-frame → cov_cnt=0, bank_sel=0.
- TILE_FEAT_EMA_EN, EMA_SHIFT=2: frame1 feat0=100 all tiles, frame2 feat0=200 → published feat0=125; frame2 feat0=0 after 100 → 75; macro off → 200.
